i2c_target_controller: RTL and testbench
========================================

Name: i2c_target_controller

Overview:
I2C target (slave) endpoint. It sits on the same sda/scl bus that the board's I2C master state machine drives, and runs entirely in the system clock domain by oversampling scl and sda. It detects START and STOP, matches a 7-bit address, ACKs it, and then does one of two things:
- Write transfer: delivers received bytes on a valid strobe.
- Read transfer: requests and shifts out bytes supplied by the user logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronisers (minimum 2).
- GLITCH_CYC, 3, number of consecutive identical synchronised samples required before a level change on scl or sda is accepted.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sda  inout  1  I2C data. Open-drain: either driven 0 or released to Z, never driven 1.
- scl  inout  1  I2C clock. Driven 0 only when CLOCK_STRETCH_EN is defined; otherwise always Z.
- slave_addr  input  7  own address. Sampled at each address byte.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- tx_data  input  8  byte to transmit in a read transfer.
- tx_req  output  1  one-cycle pulse; user must present the next tx_data.
- tx_valid  input  1  tx_data is ready. Used only with CLOCK_STRETCH_EN.
- addr_match  output  1  high from the address ACK until STOP or START.
- rw  output  1  R/W bit of the current matched transfer (1 = read).
- busy  output  1  high from START until STOP.
- stop_det  output  1  one-cycle pulse on a detected STOP.

Behaviour:
Reset:
- Synchronous, active-high. Every output goes to 0; sda and scl go to Z; state goes to IDLE; synchronisers and filters load 1.
- Reset mid-transfer releases the bus on the next clk edge.

Input conditioning:
- Each line passes through SYNC_STAGES flip-flops, then the GLITCH_CYC filter, then an edge-detect register.
- Bus-edge to internal-event latency is SYNC_STAGES + GLITCH_CYC clk cycles.

Events:
- START: filtered sda falls while scl is high.
- STOP: filtered sda rises while scl is high.
- Bits are sampled on scl rising edges. sda changes are made on the clk cycle after an scl falling edge.

States:
- IDLE: START → ADDR and busy=1.
- ADDR: shift 8 bits, MSB first. After the 8th rising edge, compare bits[7:1] to slave_addr.
  - Match, at the next scl fall: drive sda=0, set addr_match=1, latch rw = bit0, → ADDR_ACK.
  - Mismatch: → WAIT. sda is never driven.
- ADDR_ACK: release sda at the next scl fall.
  - rw=0 → RX_BYTE.
  - rw=1 → TX_BYTE, loading tx_data into the shift register on that same fall. tx_req pulses on the scl rise inside the ACK slot.
- RX_BYTE: shift 8 bits. At the scl fall after the 8th bit: rx_data updates, rx_valid pulses on the same cycle, sda=0, → RX_ACK. The target always ACKs.
- RX_ACK: release sda at the next scl fall → RX_BYTE.
- TX_BYTE: drive sda = current MSB (0 → low, 1 → Z) after each scl fall, 8 bits. After the 8th bit's fall, release sda → TX_ACK.
- TX_ACK: sample the master's ACK on the scl rise.
  - ACK (0): tx_req pulses on that rise; at the next fall load tx_data → TX_BYTE.
  - NACK (1): → WAIT.
- WAIT: sda released; wait for START or STOP.

Boundary conditions:
- START in any state (repeated start): release sda, clear addr_match, → ADDR. busy stays 1.
- STOP in any state, including mid-byte: release sda, clear addr_match and busy, pulse stop_det, → IDLE. A partial byte is discarded with no rx_valid.
- A START/STOP detected on the same cycle as an scl edge takes priority over bit shifting.
- General call (address 0x00) is not supported; it is treated as a mismatch unless slave_addr = 0.

Optional Feature:
Macro: CLOCK_STRETCH_EN.
- Defined: when tx_data is about to be loaded (ADDR_ACK or TX_ACK exit fall) and tx_valid=0, the target drives scl=0 starting the cycle after that scl fall. It holds scl low until tx_valid=1, then loads tx_data and releases scl on the following cycle.
- Also defined: after rx_valid, if tx_valid=0 (used as "receiver ready"), the target stretches until tx_valid=1 before releasing the ACK.
- Not defined: scl is never driven; tx_valid is ignored; tx_data is sampled unconditionally at the load fall.

Test Plan:
- Write 0x0E (addr 0x07, W) then data 0xAA, then STOP, with slave_addr=0x07 → sda low in both ACK slots, rx_data=0xAA, exactly one rx_valid pulse, stop_det pulse, busy ends 0.
- Address 0x10 (0x08, W) with slave_addr=0x07 → sda never driven, addr_match stays 0, no rx_valid, back to IDLE after STOP.
- Read 0x0F with tx_data=0x5A, master ACKs, then tx_data=0xC3, master NACKs → bits on sda are 0x5A then 0xC3, two tx_req pulses, sda released after the NACK.
- Write 0x0E, 0x11, then repeated START + 0x0F read → rx_data=0x11, addr_match drops and reasserts, rw=1, tx_req fires.
- STOP after 4 data bits, and separately reset after 4 data bits → no rx_valid, sda=Z, state IDLE; the next full transfer with 0x55 gives rx_data=0x55.
- CLOCK_STRETCH_EN: read with tx_valid held 0 for 200 clk → scl held 0 for ≥200 clk, released 1 cycle after tx_valid=1, correct byte shifted out.

Source files
------------

// File: rtl/i2c_target_controller.sv
// I2C target endpoint: oversampled scl/sda, START/STOP detection, 7-bit address match, byte RX/TX.
// Optional macro CLOCK_STRETCH_EN: hold scl low while tx_valid is low before a TX load or RX ACK release.
module i2c_target_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 3
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  input  logic [6:0] slave_addr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_valid,
  output logic       addr_match,
  output logic       rw,
  output logic       busy,
  output logic       stop_det
);

  localparam int CNT_W = $clog2(GLITCH_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT
  } state_t;

  state_t state, state_n;
  logic [1:0] line_raw;
  logic [SYNC_STAGES-1:0] sync_p0 [2];
  logic [CNT_W-1:0] glitch_cnt_p1 [2];
  logic [1:0] filt_p1, filt_p2;
  logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] shreg, shreg_n, rx_data_n;
  logic [3:0] bitcnt, bitcnt_n;
  logic sda_oe, sda_oe_n, stretch, stretch_n, stretch_req;
  logic rx_valid_n, tx_req_n, addr_match_n, rw_n, busy_n, stop_det_n;

  // Index 0 carries scl, index 1 carries sda through the same conditioning chain.
  assign line_raw = {sda, scl};

  // Stage p0: synchroniser; p1: glitch filter; p2: edge-detect register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_p0[i]       <= '1;
        glitch_cnt_p1[i] <= '0;
      end
      filt_p1 <= 2'b11;
      filt_p2 <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], line_raw[i]};
        if (sync_p0[i][SYNC_STAGES-1] == filt_p1[i]) begin
          glitch_cnt_p1[i] <= '0;
        end else if (glitch_cnt_p1[i] == CNT_W'(GLITCH_CYC - 1)) begin
          filt_p1[i]       <= sync_p0[i][SYNC_STAGES-1];
          glitch_cnt_p1[i] <= '0;
        end else begin
          glitch_cnt_p1[i] <= glitch_cnt_p1[i] + 1'b1;
        end
      end
      filt_p2 <= filt_p1;
    end
  end

  assign scl_f    = filt_p1[0];
  assign sda_f    = filt_p1[1];
  assign scl_rise = scl_f & ~filt_p2[0];
  assign scl_fall = ~scl_f & filt_p2[0];
  assign start_ev = filt_p2[1] & ~sda_f & scl_f & filt_p2[0];
  assign stop_ev  = ~filt_p2[1] & sda_f & scl_f & filt_p2[0];

  assign sda = sda_oe ? 1'b0 : 1'bz;

`ifdef CLOCK_STRETCH_EN
  assign stretch_req = ~tx_valid;
  assign scl = stretch ? 1'b0 : 1'bz;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = tx_valid;
  assign stretch_req = 1'b0;
  assign scl = 1'bz;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      sda_oe     <= 1'b0;
      stretch    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      state      <= state_n;
      bitcnt     <= bitcnt_n;
      sda_oe     <= sda_oe_n;
      stretch    <= stretch_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      tx_req     <= tx_req_n;
      addr_match <= addr_match_n;
      rw         <= rw_n;
      busy       <= busy_n;
      stop_det   <= stop_det_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bitcnt_n     = bitcnt;
    sda_oe_n     = sda_oe;
    stretch_n    = stretch;
    rx_data_n    = rx_data;
    rx_valid_n   = 1'b0;
    tx_req_n     = 1'b0;
    addr_match_n = addr_match;
    rw_n         = rw;
    busy_n       = busy;
    stop_det_n   = 1'b0;
    if (stop_ev) begin
      state_n      = IDLE;
      sda_oe_n     = 1'b0;
      stretch_n    = 1'b0;
      bitcnt_n     = '0;
      addr_match_n = 1'b0;
      busy_n       = 1'b0;
      stop_det_n   = 1'b1;
    end else if (start_ev) begin
      state_n      = ADDR;
      sda_oe_n     = 1'b0;
      stretch_n    = 1'b0;
      bitcnt_n     = '0;
      addr_match_n = 1'b0;
      busy_n       = 1'b1;
    end else if (stretch) begin
      // scl is held low by us, so no bus edges arrive until the user is ready.
      if (!stretch_req) begin
        stretch_n = 1'b0;
        if (state == TX_BYTE) begin
          shreg_n  = tx_data;
          sda_oe_n = ~tx_data[7];
        end
      end
    end else begin
      case (state)
        ADDR, RX_BYTE: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_f};
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            bitcnt_n = '0;
            if (state == RX_BYTE) begin
              rx_data_n  = shreg;
              rx_valid_n = 1'b1;
              sda_oe_n   = 1'b1;
              stretch_n  = stretch_req;
              state_n    = RX_ACK;
            end else if (shreg[7:1] == slave_addr) begin
              sda_oe_n     = 1'b1;
              addr_match_n = 1'b1;
              rw_n         = shreg[0];
              state_n      = ADDR_ACK;
            end else begin
              state_n = WAIT;
            end
          end
        end
        ADDR_ACK, TX_ACK: begin
          if (scl_rise) begin
            if (state == ADDR_ACK) begin
              tx_req_n = rw;
            end else if (!sda_f) begin
              tx_req_n = 1'b1;
            end else begin
              state_n = WAIT;
            end
          end else if (scl_fall) begin
            sda_oe_n = 1'b0;
            bitcnt_n = '0;
            if (state == ADDR_ACK && !rw) begin
              state_n = RX_BYTE;
            end else begin
              state_n   = TX_BYTE;
              stretch_n = stretch_req;
              if (!stretch_req) begin
                shreg_n  = tx_data;
                sda_oe_n = ~tx_data[7];
              end
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            bitcnt_n = '0;
            state_n  = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              sda_oe_n = 1'b0;
              bitcnt_n = '0;
              state_n  = TX_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_controller.sv
// Directed bench for i2c_target_controller: a bit-banged bus master drives scl/sda with pull-ups.
// The clock-stretch scenario is compiled only when CLOCK_STRETCH_EN is defined.
module tb_i2c_target_controller;
  localparam int Q = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, m_sda, m_scl, tx_valid;
  logic [6:0] slave_addr;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, tx_req, addr_match, rw, busy, stop_det;
  wire        sda, scl;

  pullup (sda);
  pullup (scl);
  assign sda = m_sda ? 1'bz : 1'b0;
  assign scl = m_scl ? 1'bz : 1'b0;

  i2c_target_controller #(.SYNC_STAGES(2), .GLITCH_CYC(3)) dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl), .slave_addr(slave_addr),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .tx_valid(tx_valid), .addr_match(addr_match), .rw(rw), .busy(busy), .stop_det(stop_det)
  );

  int vecs = 0;
  int errs = 0;
  int rx_cnt = 0, txr_cnt = 0, stop_cnt = 0, tgt_drv = 0, stretch_cyc = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt <= rx_cnt + 1;
    if (tx_req === 1'b1) txr_cnt <= txr_cnt + 1;
    if (stop_det === 1'b1) stop_cnt <= stop_cnt + 1;
    if (m_sda === 1'b1 && sda === 1'b0) tgt_drv <= tgt_drv + 1;
    if (m_scl === 1'b1 && scl === 1'b0) stretch_cyc <= stretch_cyc + 1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    int n;
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    n = 0;
    while (scl !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vecs++; errs++;
      $display("FAIL scl_wait: scl=%b, expected 1 within 2000 clk", scl);
    end
    wait_q();
    r = sda;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, d[i]);
    tx_data = next_tx;
    clk_bit(mack, r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    vecs++; if (tx_req !== 1'b0) begin errs++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    vecs++; if (addr_match !== 1'b0) begin errs++; $display("FAIL rst_addr_match: got %b want 0", addr_match); end
    vecs++; if (rw !== 1'b0) begin errs++; $display("FAIL rst_rw: got %b want 0", rw); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    vecs++; if (stop_det !== 1'b0) begin errs++; $display("FAIL rst_stop_det: got %b want 0", stop_det); end
    vecs++; if (sda !== 1'b1) begin errs++; $display("FAIL rst_sda: got %b want 1 (released)", sda); end
    vecs++; if (scl !== 1'b1) begin errs++; $display("FAIL rst_scl: got %b want 1 (released)", scl); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write();
    int rx0, st0;
    logic a;
    rx0 = rx_cnt; st0 = stop_cnt;
    i2c_start();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy_start: got %b want 1", busy); end
    send_byte(8'h0E, a);
    vecs++; if (a !== 1'b0) begin errs++; $display("FAIL wr_addr_ack: got %b want 0", a); end
    vecs++; if (addr_match !== 1'b1) begin errs++; $display("FAIL wr_addr_match: got %b want 1", addr_match); end
    vecs++; if (rw !== 1'b0) begin errs++; $display("FAIL wr_rw: got %b want 0", rw); end
    send_byte(8'hAA, a);
    vecs++; if (a !== 1'b0) begin errs++; $display("FAIL wr_data_ack: got %b want 0", a); end
    i2c_stop();
    vecs++; if (rx_data !== 8'hAA) begin errs++; $display("FAIL wr_rx_data: got %h want aa", rx_data); end
    vecs++; if (rx_cnt - rx0 !== 1) begin errs++; $display("FAIL wr_rx_valid_cnt: got %0d want 1", rx_cnt - rx0); end
    vecs++; if (stop_cnt - st0 !== 1) begin errs++; $display("FAIL wr_stop_det_cnt: got %0d want 1", stop_cnt - st0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    vecs++; if (addr_match !== 1'b0) begin errs++; $display("FAIL wr_match_end: got %b want 0", addr_match); end
  endtask

  task automatic test_addr_mismatch();
    int rx0, st0, d0;
    logic a;
    rx0 = rx_cnt; st0 = stop_cnt; d0 = tgt_drv;
    i2c_start();
    send_byte(8'h10, a);
    vecs++; if (a !== 1'b1) begin errs++; $display("FAIL mm_addr_nack: got %b want 1", a); end
    vecs++; if (addr_match !== 1'b0) begin errs++; $display("FAIL mm_addr_match: got %b want 0", addr_match); end
    send_byte(8'h33, a);
    vecs++; if (a !== 1'b1) begin errs++; $display("FAIL mm_data_nack: got %b want 1", a); end
    i2c_stop();
    vecs++; if (tgt_drv - d0 !== 0) begin errs++; $display("FAIL mm_sda_driven: got %0d cycles want 0", tgt_drv - d0); end
    vecs++; if (rx_cnt - rx0 !== 0) begin errs++; $display("FAIL mm_rx_valid_cnt: got %0d want 0", rx_cnt - rx0); end
    vecs++; if (stop_cnt - st0 !== 1) begin errs++; $display("FAIL mm_stop_det_cnt: got %0d want 1", stop_cnt - st0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mm_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read();
    int tr0;
    logic a;
    logic [7:0] d;
    tr0 = txr_cnt;
    tx_data = 8'h5A;
    i2c_start();
    send_byte(8'h0F, a);
    vecs++; if (a !== 1'b0) begin errs++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    vecs++; if (rw !== 1'b1) begin errs++; $display("FAIL rd_rw: got %b want 1", rw); end
    read_byte(1'b0, 8'hC3, d);
    vecs++; if (d !== 8'h5A) begin errs++; $display("FAIL rd_byte0: got %h want 5a", d); end
    read_byte(1'b1, 8'h00, d);
    vecs++; if (d !== 8'hC3) begin errs++; $display("FAIL rd_byte1: got %h want c3", d); end
    vecs++; if (sda !== 1'b1) begin errs++; $display("FAIL rd_sda_after_nack: got %b want 1", sda); end
    vecs++; if (txr_cnt - tr0 !== 2) begin errs++; $display("FAIL rd_tx_req_cnt: got %0d want 2", txr_cnt - tr0); end
    i2c_stop();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_repeated_start();
    int tr0;
    logic a;
    logic [7:0] d;
    tx_data = 8'h77;
    i2c_start();
    send_byte(8'h0E, a);
    send_byte(8'h11, a);
    vecs++; if (a !== 1'b0) begin errs++; $display("FAIL rs_data_ack: got %b want 0", a); end
    vecs++; if (addr_match !== 1'b1) begin errs++; $display("FAIL rs_match_before: got %b want 1", addr_match); end
    i2c_start();
    vecs++; if (addr_match !== 1'b0) begin errs++; $display("FAIL rs_match_cleared: got %b want 0", addr_match); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rs_busy_held: got %b want 1", busy); end
    tr0 = txr_cnt;
    send_byte(8'h0F, a);
    vecs++; if (a !== 1'b0) begin errs++; $display("FAIL rs_addr_ack: got %b want 0", a); end
    vecs++; if (addr_match !== 1'b1) begin errs++; $display("FAIL rs_match_again: got %b want 1", addr_match); end
    vecs++; if (rw !== 1'b1) begin errs++; $display("FAIL rs_rw: got %b want 1", rw); end
    vecs++; if (txr_cnt - tr0 !== 1) begin errs++; $display("FAIL rs_tx_req_cnt: got %0d want 1", txr_cnt - tr0); end
    vecs++; if (rx_data !== 8'h11) begin errs++; $display("FAIL rs_rx_data: got %h want 11", rx_data); end
    read_byte(1'b1, 8'h00, d);
    vecs++; if (d !== 8'h77) begin errs++; $display("FAIL rs_read_byte: got %h want 77", d); end
    i2c_stop();
  endtask

  task automatic test_partial_stop();
    int rx0;
    logic a, r;
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h0E, a);
    clk_bit(1'b1, r); clk_bit(1'b0, r); clk_bit(1'b1, r); clk_bit(1'b1, r);
    i2c_stop();
    vecs++; if (rx_cnt - rx0 !== 0) begin errs++; $display("FAIL ps_rx_valid_cnt: got %0d want 0", rx_cnt - rx0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ps_busy: got %b want 0", busy); end
    vecs++; if (sda !== 1'b1) begin errs++; $display("FAIL ps_sda: got %b want 1", sda); end
    i2c_start();
    send_byte(8'h0E, a);
    send_byte(8'h55, a);
    i2c_stop();
    vecs++; if (rx_data !== 8'h55) begin errs++; $display("FAIL ps_rx_data: got %h want 55", rx_data); end
    vecs++; if (rx_cnt - rx0 !== 1) begin errs++; $display("FAIL ps_rx_valid_after: got %0d want 1", rx_cnt - rx0); end
  endtask

  task automatic test_partial_reset();
    int rx0;
    logic a, r;
    // reset while the target is holding the address ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) clk_bit(i == 0 ? 1'b0 : (i >= 4 ? 1'b0 : 1'b1), r);
    m_sda = 1'b1;
    @(negedge clk);
    vecs++; if (sda !== 1'b0) begin errs++; $display("FAIL pr_ack_driven: got %b want 0", sda); end
    reset = 1'b1;
    @(posedge clk); #1;
    vecs++; if (sda !== 1'b1) begin errs++; $display("FAIL pr_sda_release: got %b want 1", sda); end
    @(negedge clk); reset = 1'b0;
    m_scl = 1'b1; wait_q(); wait_q();
    // reset after four data bits
    i2c_start();
    send_byte(8'h0E, a);
    clk_bit(1'b1, r); clk_bit(1'b1, r); clk_bit(1'b1, r); clk_bit(1'b1, r);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL pr_busy: got %b want 0", busy); end
    vecs++; if (addr_match !== 1'b0) begin errs++; $display("FAIL pr_addr_match: got %b want 0", addr_match); end
    vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL pr_rx_data_rst: got %h want 00", rx_data); end
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h0E, a);
    send_byte(8'h55, a);
    i2c_stop();
    vecs++; if (rx_data !== 8'h55) begin errs++; $display("FAIL pr_rx_data: got %h want 55", rx_data); end
    vecs++; if (rx_cnt - rx0 !== 1) begin errs++; $display("FAIL pr_rx_valid_cnt: got %0d want 1", rx_cnt - rx0); end
  endtask

`ifdef CLOCK_STRETCH_EN
  task automatic test_stretch();
    int s0;
    logic a, r;
    logic [7:0] d;
    tx_data = 8'h3C;
    tx_valid = 1'b0;
    i2c_start();
    send_byte(8'h0F, a);
    vecs++; if (a !== 1'b0) begin errs++; $display("FAIL st_addr_ack: got %b want 0", a); end
    s0 = stretch_cyc;
    m_scl = 1'b1;
    repeat (200) @(negedge clk);
    vecs++; if (scl !== 1'b0) begin errs++; $display("FAIL st_held: got %b want 0", scl); end
    tx_valid = 1'b1;
    @(negedge clk);
    vecs++; if (scl !== 1'b1) begin errs++; $display("FAIL st_release: got %b want 1", scl); end
    vecs++; if (stretch_cyc - s0 < 200) begin errs++; $display("FAIL st_cycles: got %0d want >=200", stretch_cyc - s0); end
    wait_q();
    d[7] = sda;
    m_scl = 1'b0;
    wait_q();
    for (int i = 6; i >= 0; i--) clk_bit(1'b1, d[i]);
    clk_bit(1'b1, r);
    vecs++; if (d !== 8'h3C) begin errs++; $display("FAIL st_byte: got %h want 3c", d); end
    i2c_stop();
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_sda = 1'b1; m_scl = 1'b1;
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h00; slave_addr = 7'h07;
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_repeated_start();
    test_partial_stop();
    test_partial_reset();
`ifdef CLOCK_STRETCH_EN
    test_stretch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
